// File: rtl/uart_i2c_bridge.sv
// uart_i2c_bridge: single-clock bridge that receives 8N1 UART bytes, queues
// them in a circular FIFO and drains them as I2C master write transactions
// (START, address+W, data bytes with ACK checking, STOP).
//
// Internal handshake: the receiver raises rx_push for exactly one cycle with
// rx_shift_q holding the byte; the FIFO accepts it only when not full.
// The I2C engine raises i_pop for one cycle to consume the head entry
// (fifo_rdata); it only does so while the FIFO is non-empty.
module uart_i2c_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int I2C_QDIV     = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [6:0]                    dev_addr,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          sda_i,
    output logic                          scl_o,
    output logic                          sda_o,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          ovf,
    output logic                          ferr,
    output logic                          nack
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int QW = (I2C_QDIV > 1) ? $clog2(I2C_QDIV) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [QW-1:0] QDIV_M1  = QW'(I2C_QDIV - 1);
    localparam logic [BW-1:0] BURST_MX = BW'(MAX_BURST);

    // Receiver states
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // I2C engine states
    localparam logic [2:0] I_IDLE     = 3'd0;
    localparam logic [2:0] I_START    = 3'd1;
    localparam logic [2:0] I_ADDR     = 3'd2;
    localparam logic [2:0] I_ADDR_ACK = 3'd3;
    localparam logic [2:0] I_DATA     = 3'd4;
    localparam logic [2:0] I_DATA_ACK = 3'd5;
    localparam logic [2:0] I_STOP     = 3'd6;

    // ---------------------------------------------------------------------
    // UART receiver
    // ---------------------------------------------------------------------
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_push;
    logic          ferr_set;

    // Two-flop synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // Receiver next-state: half-bit to mid-start, then one sample per bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    if (rx_s2_q) begin
                        // line went back high: treat as a glitch
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = '0;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_state_d = RX_IDLE;
                    rx_cnt_d   = '0;
                    if (rx_s2_q) begin
                        rx_push = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_w;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          ovf_set;
    logic [7:0]    fifo_rdata;
    logic          i_pop;

    assign level_w    = wr_ptr_q - rd_ptr_q;
    assign level      = level_w;
    assign full       = (level_w == PW'(FIFO_DEPTH));
    assign empty      = (level_w == '0);
    assign fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push while full is dropped even if a pop coincides
    always_comb begin
        fifo_wr  = rx_push && !full;
        ovf_set  = rx_push && full;
        fifo_rd  = i_pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(fifo_wr);
        rd_ptr_d = rd_ptr_q + PW'(fifo_rd);
    end

    // FIFO pointer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
        end
    end

    // ---------------------------------------------------------------------
    // I2C master engine
    // ---------------------------------------------------------------------
    logic [2:0]    i_state_q, i_state_d;
    logic [1:0]    i_phase_q, i_phase_d;
    logic [QW-1:0] i_qcnt_q, i_qcnt_d;
    logic [2:0]    i_bit_q, i_bit_d;
    logic [7:0]    i_shift_q, i_shift_d;
    logic [BW-1:0] i_burst_q, i_burst_d;
    logic          i_go_q, i_go_d;
    logic          i_tick;
    logic          nack_set;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;

    assign i_tick = (i_qcnt_q == QDIV_M1);
    assign busy   = (i_state_q != I_IDLE);
    assign scl_o  = scl_q;
    assign sda_o  = sda_q;

    // Engine sequencing: one step per quarter tick; ACK decisions at Q2,
    // state changes at the end of Q3
    always_comb begin
        i_state_d = i_state_q;
        i_phase_d = i_phase_q;
        i_qcnt_d  = i_qcnt_q;
        i_bit_d   = i_bit_q;
        i_shift_d = i_shift_q;
        i_burst_d = i_burst_q;
        i_go_d    = i_go_q;
        i_pop     = 1'b0;
        nack_set  = 1'b0;
        if (i_state_q == I_IDLE) begin
            i_qcnt_d  = '0;
            i_phase_d = 2'd0;
            if (en && !empty) begin
                i_state_d = I_START;
                i_shift_d = {dev_addr, 1'b0};
                i_burst_d = '0;
                i_bit_d   = 3'd0;
                i_go_d    = 1'b0;
            end
        end else begin
            i_qcnt_d = i_tick ? '0 : i_qcnt_q + 1'b1;
            if (i_tick) begin
                i_phase_d = i_phase_q + 2'd1;
                case (i_state_q)
                    I_START: begin
                        if (i_phase_q == 2'd3) i_state_d = I_ADDR;
                    end
                    I_ADDR, I_DATA: begin
                        if (i_phase_q == 2'd3) begin
                            i_shift_d = {i_shift_q[6:0], 1'b0};
                            if (i_bit_q == 3'd7) begin
                                i_bit_d   = 3'd0;
                                i_state_d = (i_state_q == I_ADDR) ? I_ADDR_ACK : I_DATA_ACK;
                            end else begin
                                i_bit_d = i_bit_q + 1'b1;
                            end
                        end
                    end
                    I_ADDR_ACK: begin
                        if (i_phase_q == 2'd2) begin
                            if (!sda_i) begin
                                i_pop     = 1'b1;
                                i_shift_d = fifo_rdata;
                                i_burst_d = BW'(1);
                                i_go_d    = 1'b1;
                            end else begin
                                nack_set = 1'b1;
                                i_go_d   = 1'b0;
                            end
                        end else if (i_phase_q == 2'd3) begin
                            i_state_d = i_go_q ? I_DATA : I_STOP;
                        end
                    end
                    I_DATA_ACK: begin
                        if (i_phase_q == 2'd2) begin
                            i_go_d = 1'b0;
                            if (!sda_i) begin
                                if (!empty && en && (i_burst_q < BURST_MX)) begin
                                    i_pop     = 1'b1;
                                    i_shift_d = fifo_rdata;
                                    i_burst_d = i_burst_q + 1'b1;
                                    i_go_d    = 1'b1;
                                end
                            end else begin
                                // byte already consumed; no retry
                                nack_set = 1'b1;
                            end
                        end else if (i_phase_q == 2'd3) begin
                            i_state_d = i_go_q ? I_DATA : I_STOP;
                        end
                    end
                    I_STOP: begin
                        if (i_phase_q == 2'd3) i_state_d = I_IDLE;
                    end
                    default: i_state_d = I_IDLE;
                endcase
            end
        end
    end

    // Bus levels per state and quarter; data only changes while SCL is low
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (i_state_q)
            I_START: begin
                scl_d = (i_phase_q != 2'd3);
                sda_d = (i_phase_q == 2'd0);
            end
            I_ADDR, I_DATA: begin
                scl_d = (i_phase_q == 2'd1) || (i_phase_q == 2'd2);
                sda_d = i_shift_q[7];
            end
            I_ADDR_ACK, I_DATA_ACK: begin
                scl_d = (i_phase_q == 2'd1) || (i_phase_q == 2'd2);
                sda_d = 1'b1;
            end
            I_STOP: begin
                scl_d = (i_phase_q != 2'd0);
                sda_d = i_phase_q[1];
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // Engine registers and registered (glitch-free) bus drivers
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_state_q <= I_IDLE;
            i_phase_q <= 2'd0;
            i_qcnt_q  <= '0;
            i_bit_q   <= 3'd0;
            i_shift_q <= 8'h00;
            i_burst_q <= '0;
            i_go_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            i_state_q <= i_state_d;
            i_phase_q <= i_phase_d;
            i_qcnt_q  <= i_qcnt_d;
            i_bit_q   <= i_bit_d;
            i_shift_q <= i_shift_d;
            i_burst_q <= i_burst_d;
            i_go_q    <= i_go_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky status
    // ---------------------------------------------------------------------
    logic ovf_q, ovf_d;
    logic ferr_q, ferr_d;
    logic nack_q, nack_d;

    assign ovf  = ovf_q;
    assign ferr = ferr_q;
    assign nack = nack_q;

    // Set has priority over clear
    always_comb begin
        ovf_d  = ovf_set  ? 1'b1 : (clr ? 1'b0 : ovf_q);
        ferr_d = ferr_set ? 1'b1 : (clr ? 1'b0 : ferr_q);
        nack_d = nack_set ? 1'b1 : (clr ? 1'b0 : nack_q);
    end

    // Sticky flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
            nack_q <= nack_d;
        end
    end

endmodule
